// File: rtl/qeciphy_tx_framer_pkg.sv
// Shared types, word constants and the 64-bit-per-cycle CRC-32 step for the QECIPHY TX framer.
package qeciphy_tx_framer_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } tx_state_t;

    localparam logic [63:0] FAW_PATTERN = 64'hF628_5A3C_C35A_9600;
    localparam logic [63:0] IDLE_WORD   = 64'h0707_0707_0707_0707;
    localparam logic [31:0] CRC_TAG     = 32'hC3C0_5EED;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;

    // MSB-first: data bit 63 enters the register first.
    function automatic logic [31:0] crc32_d64(input logic [31:0] crc, input logic [63:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 63; i >= 0; i--) begin
            c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

endpackage

// File: rtl/qeciphy_tx_crc32_d64.sv
// Registered CRC-32 accumulator folding in one 64-bit word per cycle; init wins over update.
module qeciphy_tx_crc32_d64
    import qeciphy_tx_framer_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
    input  logic        update_i,
    input  logic [63:0] data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init_i) begin
            crc_d = CRC_INIT;
        end else if (update_i) begin
            crc_d = crc32_d64(crc_q, data_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/qeciphy_tx_framer.sv
// QECIPHY TX framer: slot counting, OFF/IDLE/ACTIVE control and FAW/CRC/idle/data word generation.
// Define QECIPHY_TX_FRAMER_STATS_EN to add frame_count_o / data_count_o statistics outputs.
module qeciphy_tx_framer
    import qeciphy_tx_framer_pkg::*;
#(
    parameter int FAW_PERIOD = 64,
    parameter int CRC_PERIOD = 8,
    parameter int SLOT_W     = $clog2(FAW_PERIOD)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] s_axis_tdata_i,
    input  logic        s_axis_tvalid_i,
    output logic        s_axis_tready_o,
    output logic [63:0] m_axis_tdata_o,
    output logic        m_axis_tdata_isfaw_o,
    output logic        m_axis_tdata_iscrc_o,
    input  logic        link_enable_i,
    input  logic        data_enable_i,
    input  logic        rx_rdy_i,
    output logic [1:0]  tx_state_o
`ifdef QECIPHY_TX_FRAMER_STATS_EN
    ,
    output logic [31:0] frame_count_o,
    output logic [31:0] data_count_o
`endif
);

    localparam int BLK_W = $clog2(CRC_PERIOD);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FAW_PERIOD - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(CRC_PERIOD - 1);

    tx_state_t         state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic              is_faw, is_crc, is_data, at_bound;
    logic [63:0]       word_d, tdata_q;
    logic              isfaw_d, iscrc_d, isfaw_q, iscrc_q;
    logic              crc_init;
    logic [31:0]       crc_acc;

    // A separate position-in-block counter avoids a modulo on the slot counter;
    // it stays aligned because FAW_PERIOD is a multiple of CRC_PERIOD.
    assign is_faw   = (slot_q == '0);
    assign is_crc   = (blk_q == BLK_LAST);
    assign is_data  = !is_faw && !is_crc;
    assign at_bound = (slot_q == SLOT_LAST);

    always_comb begin
        slot_d = at_bound ? '0 : slot_q + SLOT_W'(1);
        blk_d  = is_crc ? '0 : blk_q + BLK_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_OFF;
            slot_q  <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (at_bound) begin
            if (!link_enable_i) begin
                state_d = ST_OFF;
            end else if (data_enable_i) begin
                state_d = ST_ACTIVE;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Word for the current slot; the CRC word uses the accumulator before its reload.
    always_comb begin
        word_d   = '0;
        isfaw_d  = 1'b0;
        iscrc_d  = 1'b0;
        crc_init = 1'b1;
        if (state_q != ST_OFF) begin
            crc_init = is_crc;
            if (is_faw) begin
                word_d  = {FAW_PATTERN[63:8], 5'b0, state_q, rx_rdy_i};
                isfaw_d = 1'b1;
            end else if (is_crc) begin
                word_d  = {CRC_TAG, ~crc_acc};
                iscrc_d = 1'b1;
            end else if (state_q == ST_ACTIVE && s_axis_tvalid_i) begin
                word_d = s_axis_tdata_i;
            end else begin
                word_d = IDLE_WORD;
            end
        end
    end

    assign s_axis_tready_o = (state_q == ST_ACTIVE) && is_data;

    qeciphy_tx_crc32_d64 u_crc (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .init_i   (crc_init),
        .update_i (1'b1),
        .data_i   (word_d),
        .crc_o    (crc_acc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tdata_q <= '0;
            isfaw_q <= 1'b0;
            iscrc_q <= 1'b0;
        end else begin
            tdata_q <= word_d;
            isfaw_q <= isfaw_d;
            iscrc_q <= iscrc_d;
        end
    end

    assign m_axis_tdata_o       = tdata_q;
    assign m_axis_tdata_isfaw_o = isfaw_q;
    assign m_axis_tdata_iscrc_o = iscrc_q;
    assign tx_state_o           = state_q;

`ifdef QECIPHY_TX_FRAMER_STATS_EN
    logic [31:0] frame_cnt_q, data_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_q <= '0;
            data_cnt_q  <= '0;
        end else begin
            if (isfaw_d) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
            if (s_axis_tvalid_i && s_axis_tready_o) begin
                data_cnt_q <= data_cnt_q + 32'd1;
            end
        end
    end

    assign frame_count_o = frame_cnt_q;
    assign data_count_o  = data_cnt_q;
`endif

endmodule

// File: tb/tb_qeciphy_tx_framer.sv
// Directed bench for qeciphy_tx_framer with FAW_PERIOD=16, CRC_PERIOD=4: a frame table plus reset sequences.
module tb_qeciphy_tx_framer;
    import qeciphy_tx_framer_pkg::*;

    localparam int FP = 16;
    localparam int CP = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [63:0] s_axis_tdata_i = '0;
    logic        s_axis_tvalid_i = 1'b0;
    logic        s_axis_tready_o;
    logic [63:0] m_axis_tdata_o;
    logic        m_axis_tdata_isfaw_o;
    logic        m_axis_tdata_iscrc_o;
    logic        link_enable_i = 1'b0;
    logic        data_enable_i = 1'b0;
    logic        rx_rdy_i = 1'b0;
    logic [1:0]  tx_state_o;
`ifdef QECIPHY_TX_FRAMER_STATS_EN
    logic [31:0] frame_count_o;
    logic [31:0] data_count_o;
`endif

    qeciphy_tx_framer #(.FAW_PERIOD(FP), .CRC_PERIOD(CP)) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .s_axis_tdata_i       (s_axis_tdata_i),
        .s_axis_tvalid_i      (s_axis_tvalid_i),
        .s_axis_tready_o      (s_axis_tready_o),
        .m_axis_tdata_o       (m_axis_tdata_o),
        .m_axis_tdata_isfaw_o (m_axis_tdata_isfaw_o),
        .m_axis_tdata_iscrc_o (m_axis_tdata_iscrc_o),
        .link_enable_i        (link_enable_i),
        .data_enable_i        (data_enable_i),
        .rx_rdy_i             (rx_rdy_i),
        .tx_state_o           (tx_state_o)
`ifdef QECIPHY_TX_FRAMER_STATS_EN
        ,
        .frame_count_o        (frame_count_o),
        .data_count_o         (data_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // One frame of stimulus and hand-written expectations; chg_slot<0 means no enable change.
    typedef struct {
        logic [1:0]  st;
        logic        rx;
        logic [15:0] vmask;
        logic [15:0] rdy;
        logic [7:0]  faw_lo;
        int          chg_slot;
        logic        link_n;
        logic        data_n;
    } frm_t;

    frm_t        tbl[7];
    int          nvec = 0;
    int          nerr = 0;
    int          cnt  = 0;
    int          fcnt = 0;
    int          dcnt = 0;
    logic [31:0] acc;
    logic [63:0] nxt = 64'h1;

    function automatic frm_t mk(logic [1:0] st, logic rx, logic [15:0] vm, logic [15:0] rdy,
                                logic [7:0] lo, int cs, logic ln, logic dn);
        frm_t f;
        f.st = st; f.rx = rx; f.vmask = vm; f.rdy = rdy; f.faw_lo = lo;
        f.chg_slot = cs; f.link_n = ln; f.data_n = dn;
        return f;
    endfunction

    function automatic logic [31:0] ref_crc(logic [31:0] c, logic [63:0] d);
        logic [31:0] r;
        logic        top;
        r = c;
        for (int b = 63; b >= 0; b--) begin
            top = r[31];
            r = r << 1;
            if (top ^ d[b]) r = r ^ 32'h04C1_1DB7;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        @(negedge clk_i);
        cnt++;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_tdata"}, m_axis_tdata_o, 64'h0);
        chk({nm, "_isfaw"}, 64'(m_axis_tdata_isfaw_o), 64'h0);
        chk({nm, "_iscrc"}, 64'(m_axis_tdata_iscrc_o), 64'h0);
        chk({nm, "_tready"}, 64'(s_axis_tready_o), 64'h0);
        chk({nm, "_state"}, 64'(tx_state_o), 64'h0);
    endtask

    task automatic run_frame(input frm_t f, input int n);
        logic [63:0] ew;
        logic        ef, ec;
        chk("frame_align", 64'(cnt % FP), 64'h0);
        acc = CRC_INIT;
        for (int i = 0; i < n; i++) begin
            rx_rdy_i = f.rx;
            if (i == f.chg_slot) begin
                link_enable_i = f.link_n;
                data_enable_i = f.data_n;
            end
            chk("tready", 64'(s_axis_tready_o), 64'(f.rdy[i]));
            s_axis_tvalid_i = f.vmask[i];
            s_axis_tdata_i  = nxt;
            ew = '0; ef = 1'b0; ec = 1'b0;
            if (f.st != 2'd0) begin
                if (i == 0) begin
                    ew = {FAW_PATTERN[63:8], f.faw_lo}; ef = 1'b1; fcnt++;
                end else if (i % CP == CP - 1) begin
                    ew = {CRC_TAG, ~acc}; ec = 1'b1;
                end else if (f.rdy[i] && f.vmask[i]) begin
                    ew = nxt; nxt++; dcnt++;
                end else begin
                    ew = IDLE_WORD;
                end
            end
            acc = (f.st == 2'd0 || ec) ? CRC_INIT : ref_crc(acc, ew);
            cyc();
            chk("tdata", m_axis_tdata_o, ew);
            chk("isfaw", 64'(m_axis_tdata_isfaw_o), 64'(ef));
            chk("iscrc", 64'(m_axis_tdata_iscrc_o), 64'(ec));
            if (i < FP - 1) chk("tx_state", 64'(tx_state_o), 64'(f.st));
        end
    endtask

    initial begin
        frm_t act_f, off_f;
        //            st    rx    vmask     rdy       lo     chg  link  data
        tbl[0] = mk(2'd1, 1'b1, 16'h0000, 16'h0000, 8'h03, -1, 1'b1, 1'b0);
        tbl[1] = mk(2'd1, 1'b0, 16'hFFFF, 16'h0000, 8'h02,  6, 1'b1, 1'b1);
        tbl[2] = mk(2'd2, 1'b1, 16'hFFFF, 16'h7776, 8'h05, -1, 1'b1, 1'b1);
        tbl[3] = mk(2'd2, 1'b1, 16'h5555, 16'h7776, 8'h05, -1, 1'b1, 1'b1);
        tbl[4] = mk(2'd2, 1'b0, 16'hFFFF, 16'h7776, 8'h04,  8, 1'b1, 1'b0);
        tbl[5] = mk(2'd1, 1'b0, 16'hAAAA, 16'h0000, 8'h02,  2, 1'b0, 1'b1);
        tbl[6] = mk(2'd0, 1'b1, 16'hFFFF, 16'h0000, 8'h00, 12, 1'b1, 1'b1);
        act_f  = mk(2'd2, 1'b1, 16'hFFFF, 16'h7776, 8'h05, -1, 1'b1, 1'b1);
        off_f  = mk(2'd0, 1'b1, 16'hFFFF, 16'h0000, 8'h00, -1, 1'b1, 1'b1);

        #1 rst_i = 1'b1;
        #1 chk_zero("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        cnt = 0;

        // Link disabled: nothing but zeros.
        for (int k = 0; k < 40; k++) begin
            cyc();
            chk_zero("off");
        end

        // Enable mid-frame; state must stay OFF until the boundary.
        rx_rdy_i = 1'b1;
        while (cnt % FP != 5) begin
            cyc();
            chk_zero("off_wait");
        end
        link_enable_i = 1'b1;
        data_enable_i = 1'b0;
        while (cnt % FP != 0) begin
            cyc();
            chk("pend_tdata", m_axis_tdata_o, 64'h0);
            if (cnt % FP != 0) chk("pend_state", 64'(tx_state_o), 64'h0);
        end
        chk("idle_entry", 64'(tx_state_o), 64'h1);

        for (int k = 0; k < 7; k++) run_frame(tbl[k], FP);

        // Reset in the middle of an ACTIVE frame.
        run_frame(act_f, 10);
        #2 rst_i = 1'b1;
        #1 chk_zero("mid_reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        cnt = 0; fcnt = 0; dcnt = 0;
        run_frame(off_f, FP);
        run_frame(act_f, FP);
        run_frame(act_f, FP);

`ifdef QECIPHY_TX_FRAMER_STATS_EN
        chk("frame_count", 64'(frame_count_o), 64'(fcnt));
        chk("data_count", 64'(data_count_o), 64'(dcnt));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
